// File: rtl/timer_sched_pkg.sv
// Shared definitions for the multi-channel timer scheduler.
package timer_sched_pkg;

  localparam int TIMER_W = 8;
  localparam int TIMER_N = 4;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // Width of a channel index for n channels (n >= 2).
  function automatic int chan_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/timer_sched_if.sv
// Command and event port of the timer scheduler.
interface timer_sched_if #(
  parameter int W = timer_sched_pkg::TIMER_W,
  parameter int N = timer_sched_pkg::TIMER_N
);
  import timer_sched_pkg::*;

  localparam int CW = chan_w(N);

  logic [W-1:0]  value;
  logic [CW-1:0] ch;
  logic          put;
  logic          periodic;
  logic [N-1:0]  busy;
  logic          fire_valid;
  logic [CW-1:0] fire_id;
  logic          fire_ready;
  logic [N-1:0]  lost;

  modport master (
    output value, ch, put, periodic, fire_ready,
    input  busy, fire_valid, fire_id, lost
  );

  modport slave (
    input  value, ch, put, periodic, fire_ready,
    output busy, fire_valid, fire_id, lost
  );

endinterface

// File: rtl/timer_sched_channel.sv
// One timeout channel: down-counter with one-shot or auto-reload mode.
module timer_sched_channel
  import timer_sched_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         cancel,
  input  logic [W-1:0] value,
  input  logic         periodic,
  output logic         busy,
  output logic         expire
);

  logic [W-1:0] count;
  logic [W-1:0] reload;
  mode_e        mode;
  logic         armed;

  assign busy = armed;

  // A command to this channel on the would-be expiry edge restarts or cancels it,
  // so the expiry is suppressed rather than reported.
  assign expire = armed && (count == W'(1)) && !load && !cancel;

  // Counter, reload and mode state; one decrement per edge while armed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      reload <= '0;
      mode   <= MODE_ONESHOT;
      armed  <= 1'b0;
    end else if (load) begin
      count  <= value;
      reload <= value;
      mode   <= periodic ? MODE_PERIODIC : MODE_ONESHOT;
      armed  <= 1'b1;
    end else if (cancel) begin
      armed  <= 1'b0;
    end else if (armed) begin
      if (count == W'(1)) begin
        if (mode == MODE_PERIODIC) begin
          count <= reload;
        end else begin
          count <= '0;
          armed <= 1'b0;
        end
      end else begin
        count <= count - W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Multi-channel timer scheduler: N timeout channels sharing one
// round-robin event port with valid/ready delivery.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int W = TIMER_W,
  parameter int N = TIMER_N
) (
  input  logic          clock,
  input  logic          reset,
  timer_sched_if.slave  bus
);

  localparam int CW = chan_w(N);

  logic [N-1:0]  arm;
  logic [N-1:0]  cancel;
  logic [N-1:0]  expire;
  logic [N-1:0]  busy;
  logic [N-1:0]  pending;
  logic [N-1:0]  lost;
  logic [N-1:0]  take;
  logic [CW-1:0] rr;
  logic [CW-1:0] pick;
  logic [CW-1:0] scan;
  logic          any;
  logic          accept;

  // Decode the put strobe into per-channel arm / cancel requests.
  always_comb begin
    arm    = '0;
    cancel = '0;
    if (bus.put) begin
      if (bus.value != '0) arm[bus.ch]    = 1'b1;
      else                 cancel[bus.ch] = 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    timer_sched_channel #(.W(W)) u_ch (
      .clock    (clock),
      .reset    (reset),
      .load     (arm[i]),
      .cancel   (cancel[i]),
      .value    (bus.value),
      .periodic (bus.periodic),
      .busy     (busy[i]),
      .expire   (expire[i])
    );
  end

  // Round-robin pick: first pending channel at or after rr, wrapping upward.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    scan = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan = rr + CW'(i);
      if (!any && pending[scan]) begin
        any  = 1'b1;
        pick = scan;
      end
    end
  end

  // One-hot of the channel handed over this cycle.
  always_comb begin
    accept = any && bus.fire_ready;
    take   = '0;
    if (accept) take[pick] = 1'b1;
  end

  // Pending/lost flags and rr pointer. Acceptance is applied before a new
  // expiry so a same-edge expiry re-raises pending without counting as lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      lost    <= '0;
      rr      <= '0;
    end else begin
      pending <= ((pending & ~take) | expire) & ~cancel;
      lost    <= (lost | (expire & pending & ~take)) & ~cancel;
      if (accept) rr <= pick + CW'(1);
    end
  end

  assign bus.busy       = busy;
  assign bus.lost       = lost;
  assign bus.fire_valid = any;
  assign bus.fire_id    = pick;

endmodule
